spi_sync_frontend: RTL and testbench

- Oversampling SPI mode-0 target front end, clocked entirely in the system clock domain.
- Sits directly upstream of the SPI RAM slave. Synchronises the pad-level PV_SCK/PV_MOSI/PV_CS, filters chip-select glitches, deserialises MOSI into bytes, and serialises response bytes onto MISO.
- Gives the downstream RAM logic a clean byte-stream interface (rx_valid / tx_req) with no SPI-clock-domain logic.

---
 rtl/spi_pkg.sv | 9 +
 rtl/sync_edge.sv | 33 +++
 rtl/spi_sync_frontend.sv | 172 +++++++++++++++++
 tb/tb_spi_sync_frontend.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the oversampling SPI target front end.
package spi_pkg;

  typedef enum logic {ST_IDLE, ST_ACTIVE} spi_state_t;

  localparam int unsigned SPI_BYTE_BITS           = 8;
  localparam int unsigned SPI_SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage pad synchroniser with one extra delay flop for edge detection.
module sync_edge
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH   = SPI_SYNC_STAGES_DEFAULT,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pad,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [DEPTH-1:0] r_sync;
  logic             r_dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {DEPTH{RST_VAL}};
      r_dly  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[DEPTH-2:0], i_pad};
      r_dly  <= r_sync[DEPTH-1];
    end
  end

  assign o_level = r_sync[DEPTH-1];
  assign o_rise  = r_sync[DEPTH-1] & ~r_dly;
  assign o_fall  = ~r_sync[DEPTH-1] & r_dly;

endmodule

// File: rtl/spi_sync_frontend.sv
// SPI mode-0 target front end oversampled in the clk domain: sync, CS filter,
// MOSI deserialiser and MISO serialiser with a byte-stream handshake.
module spi_sync_frontend
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT,
  parameter int unsigned CS_FILTER   = 3,
  parameter int unsigned TX_LATENCY  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       active,
  output logic       cs_end,
  output logic       partial
);

  localparam int unsigned CNT_W = $clog2(SPI_BYTE_BITS);

  spi_state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0]   r_mosi_sync;
  logic [CNT_W-1:0]         r_bitcnt;
  logic [3:0]               r_csf_cnt, w_csf_nxt;
  logic [SPI_BYTE_BITS-1:0] r_rx_shift, r_tx_shift, r_rx_data;
  logic [TX_LATENCY-1:0]    r_txl;
  logic r_first, r_byte_done, r_rx_valid, r_rx_first, r_tx_req;
  logic r_miso, r_active, r_cs_end, r_partial;
  logic w_go_active, w_go_idle;
  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_mosi;

  sync_edge #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .i_pad(spi_sck),
    .o_level(w_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  sync_edge #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .i_pad(spi_cs_n),
    .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  logic w_unused_edges;
  assign w_unused_edges = w_sck_level ^ w_cs_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mosi_sync <= '0;
    else     r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_csf_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_csf_cnt <= w_csf_nxt;
    end
  end

  // CS-high runs shorter than CS_FILTER (and CS falls while ACTIVE) are glitches.
  always_comb begin
    w_state_nxt = r_state;
    w_csf_nxt   = r_csf_cnt;
    w_go_active = 1'b0;
    w_go_idle   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_csf_nxt = '0;
        if (w_cs_fall) begin
          w_state_nxt = ST_ACTIVE;
          w_go_active = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!w_cs_level) begin
          w_csf_nxt = '0;
        end else if (r_csf_cnt == 4'(CS_FILTER - 1)) begin
          w_csf_nxt   = '0;
          w_state_nxt = ST_IDLE;
          w_go_idle   = 1'b1;
        end else begin
          w_csf_nxt = r_csf_cnt + 4'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt    <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_rx_data   <= '0;
      r_txl       <= '0;
      r_first     <= 1'b0;
      r_byte_done <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_first  <= 1'b0;
      r_tx_req    <= 1'b0;
      r_miso      <= 1'b0;
      r_active    <= 1'b0;
      r_cs_end    <= 1'b0;
      r_partial   <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_rx_first  <= 1'b0;
      r_tx_req    <= 1'b0;
      r_cs_end    <= 1'b0;
      r_byte_done <= 1'b0;
      r_txl[0]    <= r_tx_req;
      for (int unsigned i = 1; i < TX_LATENCY; i++) r_txl[i] <= r_txl[i-1];
      r_active <= (w_state_nxt == ST_ACTIVE);

      if (w_go_active) begin
        r_bitcnt   <= '0;
        r_rx_shift <= '0;
        r_first    <= 1'b1;
        r_tx_req   <= 1'b1;
      end else if (w_go_idle) begin
        r_cs_end   <= 1'b1;
        r_partial  <= (r_bitcnt != '0);
        r_bitcnt   <= '0;
        r_rx_shift <= '0;
        r_tx_shift <= '0;
        r_miso     <= 1'b0;
      end else if (r_state == ST_ACTIVE) begin
        if (w_sck_rise) begin
          r_rx_shift  <= {r_rx_shift[SPI_BYTE_BITS-2:0], w_mosi};
          r_bitcnt    <= r_bitcnt + 1'b1;
          r_byte_done <= (r_bitcnt == CNT_W'(SPI_BYTE_BITS - 1));
        end
        if (r_byte_done) begin
          r_rx_data  <= r_rx_shift;
          r_rx_valid <= 1'b1;
          r_rx_first <= r_first;
          r_first    <= 1'b0;
          r_tx_req   <= 1'b1;
        end
        // A pending load overrides a falling-edge shift landing in the same cycle.
        if (r_txl[TX_LATENCY-1]) begin
          r_tx_shift <= tx_data;
          r_miso     <= tx_data[SPI_BYTE_BITS-1];
        end else if (w_sck_fall && r_bitcnt != '0) begin
          r_tx_shift <= {r_tx_shift[SPI_BYTE_BITS-2:0], 1'b0};
          r_miso     <= r_tx_shift[SPI_BYTE_BITS-2];
        end
      end
    end
  end

  assign spi_miso = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_first = r_rx_first;
  assign tx_req   = r_tx_req;
  assign active   = r_active;
  assign cs_end   = r_cs_end;
  assign partial  = r_partial;

endmodule

// File: tb/tb_spi_sync_frontend.sv
// Directed bench for spi_sync_frontend: SPI master model, tx responder, pulse monitor.
module tb_spi_sync_frontend;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sck = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1;
  logic       spi_miso;
  logic [7:0] rx_data, tx_data = 8'h00;
  logic       rx_valid, rx_first, tx_req, active, cs_end, partial;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rxq_data[$];
  logic       rxq_first[$];
  logic [7:0] txq[$];
  int         n_txreq = 0;
  int         n_csend = 0;
  logic       last_partial = 1'b0;

  spi_sync_frontend #(.SYNC_STAGES(2), .CS_FILTER(3), .TX_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso), .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
    .tx_req(tx_req), .tx_data(tx_data), .active(active), .cs_end(cs_end), .partial(partial)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor and tx responder: answer tx_req by holding the next queued byte.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        rxq_data.push_back(rx_data);
        rxq_first.push_back(rx_first);
      end
      if (tx_req) begin
        n_txreq++;
        if (txq.size() > 0) tx_data = txq.pop_front();
        else                tx_data = 8'h00;
      end
      if (cs_end) begin
        n_csend++;
        last_partial = partial;
      end
    end
  end

  task automatic clear_mon();
    rxq_data.delete();
    rxq_first.delete();
    n_txreq = 0;
    n_csend = 0;
  endtask

  // Mode-0 master, SCK = clk/8; optional 2-cycle CS-high glitch at bit glitch_bit.
  task automatic xfer(input logic [7:0] b, input int nbits, input int glitch_bit,
                      output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      spi_mosi = b[7-k];
      if (7 - k == glitch_bit) begin
        spi_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        spi_cs_n = 1'b0;
      end
      repeat (4) @(negedge clk);
      miso_b[7-k] = spi_miso;
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_select();
    spi_cs_n = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  task automatic cs_release();
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  logic [7:0] m0, m1, m2;

  initial begin
    // 1: reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("idle_miso", spi_miso, 1'b0);
    check("idle_active", active, 1'b0);
    check("idle_rxdata", rx_data, 8'h00);
    check("idle_pulses", n_txreq + n_csend + rxq_data.size(), 0);

    // 2: single byte A5 / 3C
    clear_mon();
    txq.push_back(8'h3C);
    cs_select();
    check("t2_txreq_sel", n_txreq, 1);
    check("t2_active", active, 1'b1);
    xfer(8'hA5, 8, -1, m0);
    repeat (8) @(negedge clk);
    check("t2_rx_cnt", rxq_data.size(), 1);
    check("t2_rx_data", rxq_data[0], 8'hA5);
    check("t2_rx_first", rxq_first[0], 1'b1);
    check("t2_miso", m0, 8'h3C);
    cs_release();
    check("t2_csend", n_csend, 1);
    check("t2_partial", last_partial, 1'b0);
    check("t2_active_off", active, 1'b0);
    check("t2_miso_off", spi_miso, 1'b0);

    // 3: three bytes
    clear_mon();
    txq.push_back(8'h11); txq.push_back(8'h22); txq.push_back(8'h33);
    cs_select();
    xfer(8'h01, 8, -1, m0);
    xfer(8'h80, 8, -1, m1);
    xfer(8'hFF, 8, -1, m2);
    cs_release();
    check("t3_rx_cnt", rxq_data.size(), 3);
    check("t3_rx0", rxq_data[0], 8'h01);
    check("t3_rx1", rxq_data[1], 8'h80);
    check("t3_rx2", rxq_data[2], 8'hFF);
    check("t3_first", {rxq_first[0], rxq_first[1], rxq_first[2]}, 3'b100);
    check("t3_txreq", n_txreq, 4);
    check("t3_miso", {m0, m1, m2}, 24'h112233);
    check("t3_csend", n_csend, 1);
    check("t3_partial", last_partial, 1'b0);

    // 4: CS glitch mid-byte 2
    clear_mon();
    txq.push_back(8'hAA); txq.push_back(8'h55);
    cs_select();
    xfer(8'hC3, 8, -1, m0);
    xfer(8'h96, 8, 4, m1);
    repeat (4) @(negedge clk);
    check("t4_no_csend", n_csend, 0);
    check("t4_active", active, 1'b1);
    check("t4_rx_cnt", rxq_data.size(), 2);
    check("t4_rx1", rxq_data[1], 8'h96);
    check("t4_miso", {m0, m1}, 16'hAA55);
    cs_release();
    check("t4_csend", n_csend, 1);

    // 5: abort after 5 bits, then a clean transaction
    clear_mon();
    cs_select();
    xfer(8'hF0, 5, -1, m0);
    cs_release();
    check("t5_no_rx", rxq_data.size(), 0);
    check("t5_csend", n_csend, 1);
    check("t5_partial", last_partial, 1'b1);
    check("t5_miso_off", spi_miso, 1'b0);
    clear_mon();
    cs_select();
    xfer(8'h5A, 8, -1, m0);
    cs_release();
    check("t5b_rx_cnt", rxq_data.size(), 1);
    check("t5b_rx", rxq_data[0], 8'h5A);
    check("t5b_first", rxq_first[0], 1'b1);
    check("t5b_partial", last_partial, 1'b0);

    // 6: async reset mid-byte
    clear_mon();
    txq.push_back(8'hFF);
    cs_select();
    xfer(8'h00, 3, -1, m0);
    check("t6_pre_partial", partial, 1'b0);
    xfer(8'h00, 1, -1, m0);
    repeat (2) @(negedge clk);
    check("t6_pre_rxdata", rx_data, 8'h5A);
    check("t6_pre_miso", spi_miso, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_miso", spi_miso, 1'b0);
    check("t6_rst_active", active, 1'b0);
    check("t6_rst_rxdata", rx_data, 8'h00);
    check("t6_rst_pulses", {rx_valid, rx_first, tx_req, cs_end, partial}, 5'b0);
    spi_cs_n = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_no_csend", n_csend, 0);
    clear_mon();
    txq.delete();
    txq.push_back(8'hE7);
    cs_select();
    xfer(8'h3E, 8, -1, m0);
    cs_release();
    check("t6_rx_cnt", rxq_data.size(), 1);
    check("t6_rx", rxq_data[0], 8'h3E);
    check("t6_first", rxq_first[0], 1'b1);
    check("t6_miso", m0, 8'hE7);
    check("t6_csend", n_csend, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
